// File: rtl/cpsum_tx_pkg.sv
// cpsum_tx_pkg
// Shared constants and types for the c_psum AXI-Stream transmitter.
//   PSUM_TOTAL_BITS : width of the full partial-sum vector (14 x 64 x 22)
//   BEATS_DENSE     : beats per frame in the dense 64-bit packing
//   BEATS_PACK32    : beats per frame with CPSUM_TX_PACK32_EN (two sign-extended psums per beat)
//   BEAT_CNT_W      : beat counter width, sized for the larger of the two frame lengths
package cpsum_tx_pkg;

  localparam int PSUM_TOTAL_BITS = 14 * 64 * 22;
  localparam int BEATS_DENSE     = 308;
  localparam int BEATS_PACK32    = 448;
  localparam int BEAT_CNT_W      = 9;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/cpsum_beat_mux.sv
// cpsum_beat_mux
// Combinational beat selector: picks one AXI beat out of the captured psum
// vector. The only place where the packing mode is decided.
// Configuration macro: CPSUM_TX_PACK32_EN
//   undefined : dense packing, beat k = buf[64k+63:64k]
//   defined   : beat k = {sext32(psum 2k+1), sext32(psum 2k)}
// Ports:
//   buf_i  in  TOTAL_BITS : captured partial-sum vector
//   beat_i in  BEAT_CNT_W : beat index (frame counter)
//   beat_o out AXI_WIDTH  : selected beat
//   last_o out 1          : beat_i is the final beat of the frame
module cpsum_beat_mux
  import cpsum_tx_pkg::*;
#(
  parameter int TOTAL_BITS = PSUM_TOTAL_BITS,
  parameter int PSUM_WIDTH = 22,
  parameter int AXI_WIDTH  = 64
) (
  input  logic [TOTAL_BITS-1:0] buf_i,
  input  logic [BEAT_CNT_W-1:0] beat_i,
  output logic [AXI_WIDTH-1:0]  beat_o,
  output logic                  last_o
);

`ifdef CPSUM_TX_PACK32_EN
  localparam int LANE_W = AXI_WIDTH / 2;
  localparam int NPSUM  = TOTAL_BITS / PSUM_WIDTH;
  // psum count is even for every supported array size, so no half-filled beat
  localparam int BEATS  = NPSUM / 2;

  logic [AXI_WIDTH-1:0] beat_arr [BEATS];

  for (genvar k = 0; k < BEATS; k++) begin : g_beat
    localparam int LO = 2 * k * PSUM_WIDTH;
    localparam int HI = (2 * k + 1) * PSUM_WIDTH;
    assign beat_arr[k] = {{(LANE_W-PSUM_WIDTH){buf_i[HI+PSUM_WIDTH-1]}}, buf_i[HI +: PSUM_WIDTH],
                          {(LANE_W-PSUM_WIDTH){buf_i[LO+PSUM_WIDTH-1]}}, buf_i[LO +: PSUM_WIDTH]};
  end
`else
  localparam int BEATS = (TOTAL_BITS + AXI_WIDTH - 1) / AXI_WIDTH;

  // zero-pad so a non-multiple total still yields whole beats
  logic [BEATS*AXI_WIDTH-1:0] buf_pad;
  assign buf_pad = (BEATS*AXI_WIDTH)'(buf_i);

  logic [AXI_WIDTH-1:0] beat_arr [BEATS];

  for (genvar k = 0; k < BEATS; k++) begin : g_beat
    assign beat_arr[k] = buf_pad[k*AXI_WIDTH +: AXI_WIDTH];
  end
`endif

  assign beat_o = (int'(beat_i) < BEATS) ? beat_arr[beat_i] : '0;
  assign last_o = (beat_i == BEAT_CNT_W'(BEATS - 1));

endmodule

// File: rtl/cpsum_axis_tx.sv
// cpsum_axis_tx
// AXI-Stream master that captures the c_psum result vector on i_finish and
// streams it out as a frame of 64-bit beats.
// Configuration macro: CPSUM_TX_PACK32_EN (beat packing, see cpsum_beat_mux).
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   i_cpsum        : partial-sum vector, psum i at [22i+21:22i]
//   i_finish       : one-cycle pulse, i_cpsum valid in the same cycle
//   m_axis_tdata   : stream data
//   m_axis_tvalid  : stream valid (high for the whole of SEND)
//   m_axis_tready  : downstream ready
//   m_axis_tlast   : final beat of the frame
//   o_busy         : a frame is held or being sent
//   o_done         : one-cycle pulse after the last beat is accepted
//   o_overrun      : sticky, a frame arrived mid-send and was dropped
module cpsum_axis_tx
  import cpsum_tx_pkg::*;
#(
  parameter int MAC_NUMBER = 14,
  parameter int PE_NUMBER  = 64,
  parameter int PSUM_WIDTH = 22,
  parameter int AXI_WIDTH  = 64,
  localparam int TOTAL     = MAC_NUMBER * PE_NUMBER * PSUM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TOTAL-1:0]     i_cpsum,
  input  logic                 i_finish,
  output logic [AXI_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overrun
);

  tx_state_e             state_q, state_d;
  logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [TOTAL-1:0]      buf_q;
  logic                  done_q;
  logic                  overrun_q, overrun_d;
  logic                  capture;
  logic                  hs;
  logic                  hs_last;
  logic                  beat_last;
  logic [AXI_WIDTH-1:0]  beat;

  cpsum_beat_mux #(
    .TOTAL_BITS (TOTAL),
    .PSUM_WIDTH (PSUM_WIDTH),
    .AXI_WIDTH  (AXI_WIDTH)
  ) u_beat_mux (
    .buf_i  (buf_q),
    .beat_i (cnt_q),
    .beat_o (beat),
    .last_o (beat_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= hs_last;
      overrun_q <= overrun_d;
    end
  end

  // capture buffer carries no reset; it is only read while in SEND
  always_ff @(posedge clk) begin
    if (capture) buf_q <= i_cpsum;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
    hs        = (state_q == SEND) && m_axis_tready;
    hs_last   = hs && beat_last;
    case (state_q)
      IDLE: begin
        if (i_finish) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs_last) begin
          cnt_d = '0;
          // a new frame landing on the final handshake follows without a bubble
          if (i_finish) capture = 1'b1;
          else          state_d = IDLE;
        end else begin
          if (hs)       cnt_d     = cnt_q + 1'b1;
          if (i_finish) overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_axis_tvalid = (state_q == SEND);
    m_axis_tdata  = (state_q == SEND) ? beat : '0;
    m_axis_tlast  = (state_q == SEND) && beat_last;
    o_busy        = (state_q == SEND);
    o_done        = done_q;
    o_overrun     = overrun_q;
  end

endmodule

// File: tb/tb_cpsum_axis_tx.sv
module tb_cpsum_axis_tx;
  import cpsum_tx_pkg::*;

  localparam int NPS = 896;
`ifdef CPSUM_TX_PACK32_EN
  localparam int BEATS = BEATS_PACK32;
  localparam logic [63:0] A_BEAT0   = 64'h0000_0001_0000_0000;  // {1, 0}
  localparam logic [63:0] B2B_BEAT0 = 64'hFFFF_FFFF_0000_0000;  // {sext(-1), 0}
  localparam logic [63:0] R_BEAT0   = 64'h0000_03EB_0000_03E8;  // {1003, 1000}
`else
  localparam int BEATS = BEATS_DENSE;
  // psum0=0 @0, psum1=1 @22, psum2=2 @44 -> (1<<22)|(2<<44)
  localparam logic [63:0] A_BEAT0   = 64'h0000_2000_0040_0000;
  // psum1=0x3FFFFF @22, low 20 bits of psum2=0x3FFFFE @44
  localparam logic [63:0] B2B_BEAT0 = 64'hFFFF_EFFF_FFC0_0000;
  // 1000 | 1003<<22 | 1006<<44
  localparam logic [63:0] R_BEAT0   = 64'h003E_E000_FAC0_03E8;
`endif

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       i_finish = 1'b0;
  logic                       m_axis_tready = 1'b1;
  logic [PSUM_TOTAL_BITS-1:0] i_cpsum = '0;
  logic [63:0]                m_axis_tdata;
  logic                       m_axis_tvalid, m_axis_tlast, o_busy, o_done, o_overrun;

  cpsum_axis_tx dut (
    .clk           (clk),
    .rst           (rst),
    .i_cpsum       (i_cpsum),
    .i_finish      (i_finish),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_overrun     (o_overrun)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          hs_total = 0;
  bit          bp_en = 1'b0;
  logic [21:0] psum_m [NPS];
  logic [63:0] exp_data_q [$];
  logic        exp_last_q [$];
  logic        exp_ovr = 1'b0, exp_done = 1'b0;
  logic        stall_prev = 1'b0, prev_last = 1'b0;
  logic [63:0] prev_data = '0;
  logic        m_ev, m_hs, m_fl;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // expected beat straight from the psum values and the packing rule
  function automatic logic [63:0] model_beat(int k);
    logic [63:0] r;
`ifdef CPSUM_TX_PACK32_EN
    int lo, hi;
    lo = int'($signed(psum_m[2*k]));
    hi = int'($signed(psum_m[2*k+1]));
    r = {hi[31:0], lo[31:0]};
`else
    r = '0;
    for (int b = 0; b < 64; b++) begin
      int g;
      g = 64 * k + b;
      r[b] = psum_m[g / 22][g % 22];
    end
`endif
    return r;
  endfunction

  task automatic push_frame;
    for (int k = 0; k < BEATS; k++) begin
      exp_data_q.push_back(model_beat(k));
      exp_last_q.push_back(k == BEATS - 1);
    end
  endtask

  task automatic load_psum(int kind);
    for (int i = 0; i < NPS; i++) begin
      int v;
      case (kind)
        0:       v = i;
        1:       v = -i;
        2:       v = i * 7 + 3;
        3:       v = i * 3 + 1000;
        4:       v = (i == 0) ? 32'h3F_FFFF : (i == 1) ? 5 : i;
        default: v = i ^ 32'h15_5555;
      endcase
      psum_m[i] = v[21:0];
      i_cpsum[22*i +: 22] = v[21:0];
    end
  endtask

  task automatic wait_idle(string name, int budget);
    int n;
    n = 0;
    while (m_axis_tvalid && n < budget) begin
      tick;
      n++;
    end
    if (m_axis_tvalid) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout, tvalid still 1 after %0d cycles", name, budget);
    end
  endtask

  task automatic wait_hs(string name, int base, int target, int budget);
    int n;
    n = 0;
    while (hs_total - base < target && n < budget) begin
      tick;
      n++;
    end
    if (hs_total - base < target) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout, %0d handshakes, required %0d", name, hs_total - base, target);
    end
  endtask

  // model + compare, once per cycle away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_overrun", o_overrun, 0);
      exp_data_q.delete();
      exp_last_q.delete();
      exp_ovr    = 1'b0;
      exp_done   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      m_ev = (exp_data_q.size() != 0);
      chk("tvalid", m_axis_tvalid, m_ev);
      chk("busy", o_busy, m_ev);
      chk("done", o_done, exp_done);
      chk("overrun", o_overrun, exp_ovr);
      if (m_ev) begin
        chk("tdata", m_axis_tdata, exp_data_q[0]);
        chk("tlast", m_axis_tlast, exp_last_q[0]);
      end else begin
        chk("idle_tdata", m_axis_tdata, 0);
        chk("idle_tlast", m_axis_tlast, 0);
      end
      if (stall_prev) begin
        chk("stall_tdata", m_axis_tdata, prev_data);
        chk("stall_tlast", m_axis_tlast, prev_last);
      end
      m_hs       = m_ev && m_axis_tready;
      m_fl       = m_hs && exp_last_q[0];
      exp_done   = m_fl;
      stall_prev = m_ev && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (m_hs) begin
        void'(exp_data_q.pop_front());
        void'(exp_last_q.pop_front());
        hs_total++;
      end
      if (i_finish) begin
        if (!m_ev || m_fl) push_frame();
        else               exp_ovr = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = bp_en ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_tvalid", m_axis_tvalid, 0);
    chk("reset_overrun", o_overrun, 0);

    // dense/packed frame, tready always high
    load_psum(0);
    repeat (6) tick;
    i_finish = 1'b1;
    tick;
    i_finish = 1'b0;
    @(negedge clk);
    chk("a_latency_tvalid", m_axis_tvalid, 1);
    chk("a_beat0", m_axis_tdata, A_BEAT0);
    t = 1;
    while (!m_axis_tlast && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("a_tlast_offset", t, BEATS);
    chk("a_done_before_end", o_done, 0);
    @(negedge clk);
    chk("a_done_pulse", o_done, 1);
    chk("a_idle_after", m_axis_tvalid, 0);
    tick;

    // backpressure
    load_psum(2);
    bp_en = 1'b1;
    base = hs_total;
    i_finish = 1'b1;
    tick;
    i_finish = 1'b0;
    wait_idle("bp_drain", 8000);
    bp_en = 1'b0;
    chk("bp_handshakes", hs_total - base, BEATS);
    repeat (3) tick;

    // back-to-back frames
    load_psum(0);
    i_finish = 1'b1;
    tick;
    i_finish = 1'b0;
    t = 0;
    while (!m_axis_tlast && t < 2000) begin
      tick;
      t++;
    end
    chk("b2b_reached_tlast", m_axis_tlast, 1);
    load_psum(1);
    i_finish = 1'b1;
    tick;
    i_finish = 1'b0;
    @(negedge clk);
    chk("b2b_no_gap", m_axis_tvalid, 1);
    chk("b2b_beat0", m_axis_tdata, B2B_BEAT0);
    chk("b2b_done_pulse", o_done, 1);
    chk("b2b_overrun", o_overrun, 0);
    wait_idle("b2b_drain", 2000);
    chk("b2b_overrun_end", o_overrun, 0);
    repeat (3) tick;

    // overrun at beat 100
    load_psum(2);
    base = hs_total;
    i_finish = 1'b1;
    tick;
    i_finish = 1'b0;
    wait_hs("ovr_reach_100", base, 100, 1000);
    load_psum(5);
    i_finish = 1'b1;
    tick;
    i_finish = 1'b0;
    @(negedge clk);
    chk("ovr_set", o_overrun, 1);
    wait_idle("ovr_drain", 2000);
    repeat (5) tick;
    chk("ovr_held", o_overrun, 1);
    chk("ovr_no_second_frame", m_axis_tvalid, 0);
    chk("ovr_beats", hs_total - base, BEATS);

    // reset mid-frame at beat 50
    load_psum(3);
    base = hs_total;
    i_finish = 1'b1;
    tick;
    i_finish = 1'b0;
    wait_hs("rst_reach_50", base, 50, 1000);
    rst = 1'b1;
    #1;
    chk("rst_async_tvalid", m_axis_tvalid, 0);
    chk("rst_async_tlast", m_axis_tlast, 0);
    chk("rst_clears_overrun", o_overrun, 0);
    repeat (2) tick;
    rst = 1'b0;
    tick;
    base = hs_total;
    i_finish = 1'b1;
    tick;
    i_finish = 1'b0;
    @(negedge clk);
    chk("rst_new_beat0", m_axis_tdata, R_BEAT0);
    wait_idle("rst_new_drain", 2000);
    chk("rst_new_beats", hs_total - base, BEATS);
    repeat (3) tick;

`ifdef CPSUM_TX_PACK32_EN
    load_psum(4);
    base = hs_total;
    i_finish = 1'b1;
    tick;
    i_finish = 1'b0;
    @(negedge clk);
    chk("pack_beat0", m_axis_tdata, 64'h0000_0005_FFFF_FFFF);
    wait_idle("pack_drain", 2000);
    chk("pack_beats", hs_total - base, 448);
    repeat (3) tick;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
